div_issue_stage: RTL and testbench

Upstream issue stage for the 8-bit restoring divider `div`. It accepts dividend/divisor pairs over a valid/ready handshake and buffers them in a small FIFO. It drives one operand pair at a time from registers into `div`, captures `div`'s quotient and divide-by-zero flag one cycle later, and returns the result with its tag over a second valid/ready handshake. It owns all sequencing around the divider. The divider itself is instantiated beside this block at the parent level.

---
 rtl/div_pkg.sv | 16 +
 rtl/div_fifo.sv | 53 +++++
 rtl/div_issue_stage.sv | 126 ++++++++++++
 tb/tb_div_issue_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and default sizes for the divider issue stage.
package div_pkg;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_DEPTH = 4;
  localparam int DIV_TAG_W = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] dividend;
    logic [DIV_WIDTH-1:0] divisor;
    logic [DIV_TAG_W-1:0] tag;
  } div_entry_t;

endpackage

// File: rtl/div_fifo.sv
// Small synchronous FIFO with a combinational head read and an explicit occupancy count.
module div_fifo #(
  parameter int ENTRY_W = 18,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ENTRY_W-1:0]         din,
  output logic [ENTRY_W-1:0]         dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               push_ok, pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign dout    = mem_reg[rd_ptr_reg];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/div_issue_stage.sv
// Buffers operand pairs, feeds them one at a time to the external divider and
// returns the registered quotient with its tag over a valid/ready handshake.
module div_issue_stage
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int DEPTH = DIV_DEPTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_dividend,
  input  logic [WIDTH-1:0] op_divisor,
  input  logic [TAG_W-1:0] op_tag,
  output logic [WIDTH-1:0] div_in1,
  output logic [WIDTH-1:0] div_in2,
  input  logic [WIDTH-1:0] div_out,
  input  logic             div_dbz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_q,
  output logic             res_dbz,
  output logic [TAG_W-1:0] res_tag
);

  localparam int ENTRY_W = 2 * WIDTH + TAG_W;

  typedef struct packed {
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t                  state_reg, state_next;
  entry_t                  push_entry, head_entry;
  logic                    push, pop, full, empty, can_pop;
  logic [$clog2(DEPTH):0]  count;
  logic [WIDTH-1:0]        in1_reg, in2_reg, res_q_reg;
  logic [TAG_W-1:0]        issue_tag_reg, res_tag_reg;
  logic                    res_valid_reg, res_dbz_reg;

  assign op_ready   = !full;
  assign push       = op_valid && !full;
  assign push_entry = '{dividend: op_dividend, divisor: op_divisor, tag: op_tag};
  assign can_pop    = (count != '0) && !empty;

  div_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (can_pop) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      // One full cycle with stable operands lets the divider settle.
      ISSUE: state_next = HOLD;
      HOLD: begin
        if (res_ready) begin
          if (can_pop) begin
            pop        = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      in1_reg       <= '0;
      in2_reg       <= '0;
      issue_tag_reg <= '0;
      res_valid_reg <= 1'b0;
      res_q_reg     <= '0;
      res_dbz_reg   <= 1'b0;
      res_tag_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        in1_reg       <= head_entry.dividend;
        in2_reg       <= head_entry.divisor;
        issue_tag_reg <= head_entry.tag;
      end
      if (state_reg == ISSUE) begin
        // The divider leaves its output stale on a zero divisor, so mask it.
        res_valid_reg <= 1'b1;
        res_q_reg     <= div_dbz ? '0 : div_out;
        res_dbz_reg   <= div_dbz;
        res_tag_reg   <= issue_tag_reg;
      end else if (state_reg == HOLD && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign div_in1   = in1_reg;
  assign div_in2   = in2_reg;
  assign res_valid = res_valid_reg;
  assign res_q     = res_q_reg;
  assign res_dbz   = res_dbz_reg;
  assign res_tag   = res_tag_reg;

endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage with a behavioural divider wired back-to-back.
module tb_div_issue_stage;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [7:0] op_dividend;
  logic [7:0] op_divisor;
  logic [1:0] op_tag;
  logic [7:0] div_in1;
  logic [7:0] div_in2;
  logic [7:0] div_out;
  logic       div_dbz;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_q;
  logic       res_dbz;
  logic [1:0] res_tag;

  int checks = 0;
  int errors = 0;

  div_issue_stage u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_dividend (op_dividend),
    .op_divisor  (op_divisor),
    .op_tag      (op_tag),
    .div_in1     (div_in1),
    .div_in2     (div_in2),
    .div_out     (div_out),
    .div_dbz     (div_dbz),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_q       (res_q),
    .res_dbz     (res_dbz),
    .res_tag     (res_tag)
  );

  // Divider stand-in: garbage output on zero divisor, as the real one leaves it stale.
  always_comb begin
    div_dbz = (div_in2 == 8'd0);
    div_out = div_dbz ? 8'hA5 : (div_in1 / div_in2);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
    op_valid    = v;
    op_dividend = a;
    op_divisor  = b;
    op_tag      = t;
  endtask

  function automatic logic [10:0] pk(input logic d, input logic [7:0] q, input logic [1:0] t);
    return {d, q, t};
  endfunction

  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] t);
    if (b == 8'd0) return pk(1'b1, 8'd0, t);
    return pk(1'b0, a / b, t);
  endfunction

  // Waits (bounded) for a result, checks it, then lets res_ready consume it.
  task automatic wait_res(input string nm, input logic [10:0] exp);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_valid"}, {31'd0, res_valid}, 32'd1);
    check({nm, "_res"}, {21'd0, res_dbz, res_q, res_tag}, {21'd0, exp});
    tick();
  endtask

  logic [10:0] sb [$];
  logic [10:0] e;
  logic [7:0]  bp_q [5];
  logic [7:0]  a, b;

  initial begin
    bp_q = '{8'd50, 8'd30, 8'd23, 8'd20, 8'd18};
    rst_n = 1'b0;
    res_ready = 1'b0;
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    tick();
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res", {21'd0, res_dbz, res_q, res_tag}, 32'd0);
    check("rst_div_in", {16'd0, div_in1, div_in2}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single op with latency check.
    res_ready = 1'b1;
    set_op(1'b1, 8'd100, 8'd7, 2'd1);
    tick();
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    check("single_lat1", {31'd0, res_valid}, 32'd0);
    tick();
    check("single_div_in", {16'd0, div_in1, div_in2}, {16'd0, 8'd100, 8'd7});
    check("single_lat2", {31'd0, res_valid}, 32'd0);
    tick();
    check("single_valid", {31'd0, res_valid}, 32'd1);
    check("single_res", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b0, 8'd14, 2'd1)});
    tick();
    check("single_done", {31'd0, res_valid}, 32'd0);
    tick();
    check("idle_hold_div_in", {16'd0, div_in1, div_in2}, {16'd0, 8'd100, 8'd7});

    // Divide by zero followed by a normal op.
    set_op(1'b1, 8'd200, 8'd0, 2'd2);
    tick();
    set_op(1'b1, 8'd255, 8'd1, 2'd3);
    tick();
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    tick();
    check("dbz_valid", {31'd0, res_valid}, 32'd1);
    check("dbz_res", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b1, 8'd0, 2'd2)});
    tick();
    check("dbz_gap", {31'd0, res_valid}, 32'd0);
    tick();
    check("after_dbz_res", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b0, 8'd255, 2'd3)});
    tick();
    tick();

    // Backpressure: five pushes, FIFO fills behind the first issued pair.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_ready_before", {31'd0, op_ready}, 32'd1);
      set_op(1'b1, 8'(50 + 10 * i), 8'(i + 1), 2'(i));
      tick();
    end
    check("bp_full", {31'd0, op_ready}, 32'd0);
    set_op(1'b1, 8'd77, 8'd7, 2'd3);
    tick();
    check("bp_still_full", {31'd0, op_ready}, 32'd0);
    check("bp_first_valid", {31'd0, res_valid}, 32'd1);
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    res_ready = 1'b1;
    check("bp_res0", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b0, bp_q[0], 2'd0)});
    for (int i = 1; i < 5; i++) begin
      tick();
      check("bp_gap", {31'd0, res_valid}, 32'd0);
      tick();
      check("bp_valid", {31'd0, res_valid}, 32'd1);
      check("bp_res", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b0, bp_q[i], 2'(i))});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_no_extra", {31'd0, res_valid}, 32'd0);
    end

    // Simultaneous push/pop at count=2 across pointer wrap.
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = 8'(17 * k + 3);
      b = 8'(k % 4);
      set_op(1'b1, a, b, 2'(k));
      sb.push_back(model(a, b, 2'(k)));
      tick();
    end
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    tick();
    check("ww_count_init", {29'd0, u_dut.u_fifo.count}, 32'd2);
    res_ready = 1'b1;
    for (int k = 3; k < 13; k++) begin
      e = sb.pop_front();
      check("ww_valid", {31'd0, res_valid}, 32'd1);
      check("ww_res", {21'd0, res_dbz, res_q, res_tag}, {21'd0, e});
      a = 8'(17 * k + 3);
      b = 8'(k % 4);
      set_op(1'b1, a, b, 2'(k));
      sb.push_back(model(a, b, 2'(k)));
      tick();
      check("ww_count", {29'd0, u_dut.u_fifo.count}, 32'd2);
      check("ww_gap", {31'd0, res_valid}, 32'd0);
      set_op(1'b0, 8'd0, 8'd0, 2'd0);
      tick();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_res("ww_drain", e);
    end
    tick();

    // Reset while a pair is in ISSUE with three entries queued.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, 8'(10 + i), 8'd1, 2'(i));
      tick();
    end
    res_ready = 1'b1;
    set_op(1'b1, 8'd99, 8'd3, 2'd1);
    tick();
    check("rst_mid_count", {29'd0, u_dut.u_fifo.count}, 32'd3);
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst_mid_valid", {31'd0, res_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, op_ready}, 32'd1);
    check("rst_mid_div_in", {16'd0, div_in1, div_in2}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("rst_no_stale", {31'd0, res_valid}, 32'd0);
    end

    // Result stays stable under backpressure while new pairs arrive.
    res_ready = 1'b0;
    set_op(1'b1, 8'd123, 8'd4, 2'd3);
    tick();
    set_op(1'b0, 8'd0, 8'd0, 2'd0);
    tick();
    tick();
    check("hold_valid", {31'd0, res_valid}, 32'd1);
    for (int j = 0; j < 5; j++) begin
      if (j < 4) set_op(1'b1, 8'(40 + j), 8'd2, 2'(j));
      else set_op(1'b0, 8'd0, 8'd0, 2'd0);
      tick();
      check("hold_stable", {21'd0, res_dbz, res_q, res_tag}, {21'd0, pk(1'b0, 8'd30, 2'd3)});
      check("hold_valid_cyc", {31'd0, res_valid}, 32'd1);
    end
    check("hold_full", {31'd0, op_ready}, 32'd0);
    res_ready = 1'b1;
    wait_res("hold_first", pk(1'b0, 8'd30, 2'd3));
    for (int j = 0; j < 4; j++) begin
      wait_res("hold_drain", model(8'(40 + j), 8'd2, 2'(j)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
